// File: rtl/calc_issue_ctrl.sv
// Requester for an external 4-bit combinational calculator. Issues one command at a time,
// holds the operands while the calculator settles, then queues R/ovf in a FWFT result FIFO.
module calc_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             cmd_acc,
    output logic [2:0]       calc_op,
    output logic [3:0]       calc_a,
    output logic [3:0]       calc_b,
    input  logic [3:0]       calc_r,
    input  logic             calc_ovf,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_r,
    output logic             res_ovf,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]       r_state;
    logic [3:0]       r_settle;
    logic [2:0]       r_calc_op;
    logic [3:0]       r_calc_a;
    logic [3:0]       r_calc_b;
    logic [3:0]       r_acc;
    logic [CNT_W-1:0] r_ovf_cnt;

    logic [4:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_empty;

    assign w_empty  = (r_count == '0);
    assign cmd_ready = (r_state == S_IDLE) && (r_count < DEPTH_C);
    assign w_accept = cmd_valid && cmd_ready;
    assign w_push   = (r_state == S_CAPTURE);
    assign w_pop    = res_valid && res_ready;

    assign calc_op   = r_calc_op;
    assign calc_a    = r_calc_a;
    assign calc_b    = r_calc_b;
    assign busy      = (r_state != S_IDLE);
    assign ovf_count = r_ovf_cnt;
    assign res_valid = !w_empty;
    assign res_r     = w_empty ? 4'd0 : r_mem[r_rptr][4:1];
    assign res_ovf   = w_empty ? 1'b0 : r_mem[r_rptr][0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_settle  <= '0;
            r_calc_op <= '0;
            r_calc_a  <= '0;
            r_calc_b  <= '0;
            r_acc     <= '0;
            r_ovf_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_calc_op <= cmd_op;
                        r_calc_b  <= cmd_b;
                        r_calc_a  <= cmd_acc ? r_acc : cmd_a;
                        r_settle  <= SETTLE_LOAD;
                        r_state   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == '0) r_state <= S_CAPTURE;
                    else                r_settle <= r_settle - 4'd1;
                end
                S_CAPTURE: begin
                    r_acc <= calc_r;
                    // Saturate rather than wrap so a stuck-overflow source stays visible.
                    if (calc_ovf && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {calc_r, calc_ovf};
    end

endmodule
